// File: rtl/rom_reader_pkg.sv
// Shared definitions for the address key conditioner: FSM state codes and
// default timing constants.
package rom_reader_pkg;

    typedef logic [2:0] key_state_t;

    localparam key_state_t ST_IDLE       = 3'd0;
    localparam key_state_t ST_PRESS_INC  = 3'd1;
    localparam key_state_t ST_PRESS_DEC  = 3'd2;
    localparam key_state_t ST_REPEAT_INC = 3'd3;
    localparam key_state_t ST_REPEAT_DEC = 3'd4;
    localparam key_state_t ST_LOCKOUT    = 3'd5;

    localparam int DEF_DEBOUNCE_CYCLES      = 16;
    localparam int DEF_REPEAT_DELAY_CYCLES  = 1000;
    localparam int DEF_REPEAT_PERIOD_CYCLES = 250;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer followed by a consecutive-sample debounce counter for
// one active-low key. Output is the debounced level (1 = released).
module key_debouncer
    import rom_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_key_n,
    output logic o_key_n
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sync_key;

    assign w_sync_key = r_sync[1];

    // NOTE: synchronizer flops are reset to "released" so a key held through
    // reset must be re-debounced before it can count as a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments keep both flops sampling the
            // pre-edge values, giving a true two-stage pipeline.
            r_sync <= {r_sync[0], i_key_n};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else if (w_sync_key != r_level) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= w_sync_key;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_key_n = r_level;

endmodule

// File: rtl/address_key_conditioner.sv
// Turns two raw push-buttons into single-cycle ROM address step pulses.
// Optional auto-repeat is enabled by defining ADDRESS_KEY_AUTO_REPEAT_EN.
module address_key_conditioner
    import rom_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_inc_n,
    input  logic       key_dec_n,
    output logic       increment_address,
    output logic       decrement_address,
    output logic [2:0] key_state
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_params
        $error("address_key_conditioner: timing parameters must be >= 1");
    end

    logic       w_inc_n;
    logic       w_dec_n;
    logic       w_inc;
    logic       w_dec;
    key_state_t r_state;
    key_state_t w_state_nxt;
    logic       r_inc_pulse;
    logic       r_dec_pulse;
    logic       w_inc_nxt;
    logic       w_dec_nxt;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
        .clk     (clk),
        .reset_n (reset_n),
        .i_key_n (key_inc_n),
        .o_key_n (w_inc_n)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dec (
        .clk     (clk),
        .reset_n (reset_n),
        .i_key_n (key_dec_n),
        .o_key_n (w_dec_n)
    );

    assign w_inc = ~w_inc_n;
    assign w_dec = ~w_dec_n;

`ifdef ADDRESS_KEY_AUTO_REPEAT_EN
    localparam int MAX_T   = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int TIMER_W = $clog2(MAX_T) + 1;

    logic [TIMER_W-1:0] r_timer;
    logic               w_delay_done;
    logic               w_period_done;
    logic               w_reload;

    assign w_delay_done  = (r_timer == TIMER_W'(REPEAT_DELAY_CYCLES - 1));
    assign w_period_done = (r_timer == TIMER_W'(REPEAT_PERIOD_CYCLES - 1));
    // A repeat pulse restarts the period just like a state change does.
    assign w_reload      = (w_state_nxt != r_state) || w_inc_nxt || w_dec_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (w_reload || r_state == ST_IDLE || r_state == ST_LOCKOUT) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_inc_nxt   = 1'b0;
        w_dec_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_inc && w_dec) begin
                    w_state_nxt = ST_LOCKOUT;
                end else if (w_inc) begin
                    w_state_nxt = ST_PRESS_INC;
                    w_inc_nxt   = 1'b1;
                end else if (w_dec) begin
                    w_state_nxt = ST_PRESS_DEC;
                    w_dec_nxt   = 1'b1;
                end
            end
            ST_PRESS_INC: begin
                if (w_dec) begin
                    w_state_nxt = ST_LOCKOUT;
                end else if (!w_inc) begin
                    w_state_nxt = ST_IDLE;
`ifdef ADDRESS_KEY_AUTO_REPEAT_EN
                end else if (w_delay_done) begin
                    w_state_nxt = ST_REPEAT_INC;
                    w_inc_nxt   = 1'b1;
`endif
                end
            end
            ST_PRESS_DEC: begin
                if (w_inc) begin
                    w_state_nxt = ST_LOCKOUT;
                end else if (!w_dec) begin
                    w_state_nxt = ST_IDLE;
`ifdef ADDRESS_KEY_AUTO_REPEAT_EN
                end else if (w_delay_done) begin
                    w_state_nxt = ST_REPEAT_DEC;
                    w_dec_nxt   = 1'b1;
`endif
                end
            end
`ifdef ADDRESS_KEY_AUTO_REPEAT_EN
            ST_REPEAT_INC: begin
                if (w_dec) begin
                    w_state_nxt = ST_LOCKOUT;
                end else if (!w_inc) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_period_done) begin
                    w_inc_nxt = 1'b1;
                end
            end
            ST_REPEAT_DEC: begin
                if (w_inc) begin
                    w_state_nxt = ST_LOCKOUT;
                end else if (!w_dec) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_period_done) begin
                    w_dec_nxt = 1'b1;
                end
            end
`endif
            ST_LOCKOUT: begin
                if (!w_inc && !w_dec) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_inc_pulse <= 1'b0;
            r_dec_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_inc_pulse <= w_inc_nxt;
            r_dec_pulse <= w_dec_nxt;
        end
    end

    assign increment_address = r_inc_pulse;
    assign decrement_address = r_dec_pulse;
    assign key_state         = r_state;

endmodule

// File: tb/tb_address_key_conditioner.sv
// Self-checking bench for address_key_conditioner (DEBOUNCE=4, DELAY=20,
// PERIOD=8); expectations follow ADDRESS_KEY_AUTO_REPEAT_EN if defined.
module tb_address_key_conditioner;
    import rom_reader_pkg::*;

    localparam int DEB = 4;
    localparam int DLY = 20;
    localparam int PER = 8;
`ifdef ADDRESS_KEY_AUTO_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       key_inc_n;
    logic       key_dec_n;
    logic       increment_address;
    logic       decrement_address;
    logic [2:0] key_state;

    always #5 clk = ~clk;

    address_key_conditioner #(
        .DEBOUNCE_CYCLES      (DEB),
        .REPEAT_DELAY_CYCLES  (DLY),
        .REPEAT_PERIOD_CYCLES (PER)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .key_inc_n         (key_inc_n),
        .key_dec_n         (key_dec_n),
        .increment_address (increment_address),
        .decrement_address (decrement_address),
        .key_state         (key_state)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    string cur_test = "";
    int    inc_log[$];
    int    dec_log[$];

    // Reference model: synchronizer history, debounce run length, and which
    // key currently "owns" the conditioner plus how long it has been held.
    bit m_s1_inc, m_s2_inc, m_db_inc;
    bit m_s1_dec, m_s2_dec, m_db_dec;
    int m_run_inc, m_run_dec;
    int m_owner;   // 0 none, 1 inc, 2 dec, 3 both-locked
    int m_age;
    bit m_exp_inc, m_exp_dec;

    task automatic model_reset();
        m_s1_inc = 1; m_s2_inc = 1; m_db_inc = 1; m_run_inc = 0;
        m_s1_dec = 1; m_s2_dec = 1; m_db_dec = 1; m_run_dec = 0;
        m_owner = 0; m_age = 0; m_exp_inc = 0; m_exp_dec = 0;
    endtask

    task automatic debounce(input bit s, inout bit db, inout int run);
        if (s != db) begin
            run++;
            if (run == DEB) begin
                db  = s;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_edge();
        bit inc_p, dec_p, mine, other, fire;
        inc_p = !m_db_inc;
        dec_p = !m_db_dec;
        m_exp_inc = 0;
        m_exp_dec = 0;
        case (m_owner)
            0: begin
                if (inc_p && dec_p) m_owner = 3;
                else if (inc_p) begin m_owner = 1; m_age = 0; m_exp_inc = 1; end
                else if (dec_p) begin m_owner = 2; m_age = 0; m_exp_dec = 1; end
            end
            1, 2: begin
                mine  = (m_owner == 1) ? inc_p : dec_p;
                other = (m_owner == 1) ? dec_p : inc_p;
                if (other) m_owner = 3;
                else if (!mine) m_owner = 0;
                else begin
                    m_age++;
                    fire = REPEAT_EN && (m_age >= DLY) && ((m_age - DLY) % PER == 0);
                    if (fire && m_owner == 1) m_exp_inc = 1;
                    if (fire && m_owner == 2) m_exp_dec = 1;
                end
            end
            default: if (!inc_p && !dec_p) m_owner = 0;
        endcase
        debounce(m_s2_inc, m_db_inc, m_run_inc);
        debounce(m_s2_dec, m_db_dec, m_run_dec);
        m_s2_inc = m_s1_inc; m_s1_inc = key_inc_n;
        m_s2_dec = m_s1_dec; m_s1_dec = key_dec_n;
    endtask

    function automatic key_state_t exp_state();
        bit rep;
        rep = REPEAT_EN && (m_age >= DLY);
        case (m_owner)
            1:       return rep ? ST_REPEAT_INC : ST_PRESS_INC;
            2:       return rep ? ST_REPEAT_DEC : ST_PRESS_DEC;
            3:       return ST_LOCKOUT;
            default: return ST_IDLE;
        endcase
    endfunction

    task automatic step();
        key_state_t es;
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        cyc++;
        es = exp_state();
        checks++;
        if (increment_address !== m_exp_inc) begin
            errors++;
            $display("FAIL %s inc_pulse cyc %0d: got %b expected %b", cur_test, cyc, increment_address, m_exp_inc);
        end
        checks++;
        if (decrement_address !== m_exp_dec) begin
            errors++;
            $display("FAIL %s dec_pulse cyc %0d: got %b expected %b", cur_test, cyc, decrement_address, m_exp_dec);
        end
        checks++;
        if (key_state !== es) begin
            errors++;
            $display("FAIL %s key_state cyc %0d: got %0d expected %0d", cur_test, cyc, key_state, es);
        end
        if (increment_address === 1'b1) inc_log.push_back(cyc);
        if (decrement_address === 1'b1) dec_log.push_back(cyc);
    endtask

    task automatic clear_logs();
        cyc = 0;
        inc_log.delete();
        dec_log.delete();
    endtask

    task automatic test_reset();
        cur_test  = "reset";
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        reset_n   = 1'b0;
        model_reset();
        #1;
        checks++;
        if (increment_address !== 1'b0 || decrement_address !== 1'b0 || key_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_values: got inc=%b dec=%b state=%0d expected 0 0 %0d",
                     increment_address, decrement_address, key_state, ST_IDLE);
        end
        // A key pressed while reset is held must produce nothing.
        key_inc_n = 1'b0;
        repeat (12) step();
        key_inc_n = 1'b1;
        reset_n   = 1'b1;
        repeat (10) step();
    endtask

    task automatic test_hold(input bit use_inc);
        int exp_q[$];
        cur_test = use_inc ? "hold_inc" : "hold_dec";
        clear_logs();
        exp_q.push_back(DEB + 3);
        if (REPEAT_EN)
            for (int t = DEB + 3 + DLY; t <= 100; t += PER) exp_q.push_back(t);
        if (use_inc) key_inc_n = 1'b0;
        else         key_dec_n = 1'b0;
        repeat (100) step();
        checks++;
        if ((use_inc ? inc_log.size() : dec_log.size()) != exp_q.size()) begin
            errors++;
            $display("FAIL %s pulse_count: got %0d expected %0d", cur_test,
                     use_inc ? inc_log.size() : dec_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            int got;
            got = -1;
            if (use_inc && i < inc_log.size()) got = inc_log[i];
            if (!use_inc && i < dec_log.size()) got = dec_log[i];
            checks++;
            if (got != exp_q[i]) begin
                errors++;
                $display("FAIL %s pulse_%0d_cycle: got %0d expected %0d", cur_test, i, got, exp_q[i]);
            end
        end
        checks++;
        if ((use_inc ? dec_log.size() : inc_log.size()) != 0) begin
            errors++;
            $display("FAIL %s other_output_quiet: got %0d pulses expected 0", cur_test,
                     use_inc ? dec_log.size() : inc_log.size());
        end
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        repeat (20) step();
    endtask

    task automatic test_bounce_dec();
        cur_test = "bounce_dec";
        clear_logs();
        for (int i = 0; i < 30; i++) begin
            key_dec_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
        end
        key_dec_n = 1'b1;
        repeat (20) step();
        checks++;
        if (inc_log.size() + dec_log.size() != 0) begin
            errors++;
            $display("FAIL bounce_dec no_pulses: got %0d expected 0", inc_log.size() + dec_log.size());
        end
    endtask

    task automatic test_lockout();
        cur_test = "lockout";
        clear_logs();
        key_inc_n = 1'b0;
        key_dec_n = 1'b0;
        repeat (50) step();
        key_inc_n = 1'b1;
        repeat (50) step();
        checks++;
        if (key_state !== ST_LOCKOUT) begin
            errors++;
            $display("FAIL lockout held_state: got %0d expected %0d", key_state, ST_LOCKOUT);
        end
        key_dec_n = 1'b1;
        repeat (20) step();
        checks++;
        if (key_state !== ST_IDLE) begin
            errors++;
            $display("FAIL lockout release_state: got %0d expected %0d", key_state, ST_IDLE);
        end
        checks++;
        if (inc_log.size() + dec_log.size() != 0) begin
            errors++;
            $display("FAIL lockout no_pulses: got %0d expected 0", inc_log.size() + dec_log.size());
        end
    endtask

    task automatic test_reset_mid_repeat();
        int first;
        cur_test = "reset_mid";
        clear_logs();
        key_inc_n = 1'b0;
        repeat (25) step();
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (increment_address !== 1'b0 || key_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_mid abort: got inc=%b state=%0d expected 0 %0d",
                     increment_address, key_state, ST_IDLE);
        end
        repeat (3) step();
        reset_n = 1'b1;
        clear_logs();
        first = -1;
        for (int i = 0; i < 20 && first < 0; i++) begin
            step();
            if (inc_log.size() != 0) first = inc_log[0];
        end
        checks++;
        if (first != DEB + 3) begin
            errors++;
            $display("FAIL reset_mid first_pulse_after_reset: got %0d expected %0d", first, DEB + 3);
        end
        key_inc_n = 1'b1;
        repeat (20) step();
    endtask

    task automatic test_random();
        cur_test = "random";
        clear_logs();
        for (int seg = 0; seg < 60; seg++) begin
            int len, mode;
            len  = $urandom_range(1, 60);
            mode = $urandom_range(0, 9);
            for (int i = 0; i < len; i++) begin
                if (mode < 3) begin
                    key_inc_n = $urandom_range(0, 1);
                    key_dec_n = $urandom_range(0, 3) != 0;
                end else if (i == 0) begin
                    key_inc_n = $urandom_range(0, 2) != 0;
                    key_dec_n = $urandom_range(0, 2) != 0;
                end
                if (mode == 9 && i == len / 2) begin
                    reset_n = 1'b0;
                    model_reset();
                end
                step();
                if (reset_n == 1'b0 && i == len / 2 + 1) reset_n = 1'b1;
            end
            reset_n = 1'b1;
        end
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        repeat (30) step();
    endtask

    initial begin
        test_reset();
        test_hold(1'b1);
        test_hold(1'b0);
        test_bounce_dec();
        test_lockout();
        test_reset_mid_repeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
